bpu_upd_sched: RTL and testbench
================================

Name: bpu_upd_sched

Overview:
- Collects resolved-branch training updates from two execute lanes and stores them in a small FIFO.
- Issues them to the branch prediction unit's single flush/update port at a rate of at most one per cycle.
- Sits between the execute lanes (lane 0 = main EXU, lane 1 = secondary lane) and the BPU.
- Provides per-cycle fair arbitration, backpressure, a pipeline-kill drop and a hold for debug/fence sequences.

Parameters:
N_ADDR_BITS, `BP_ADDR_BITS, width of the BPU-tag PC (flush_bp_pc).
N_DATA_BITS, 32, target/RAS PC width.
N_FLUSH_BYTE_BITS, 4, branch type one-hot {call, ret, jal_jalr, branch}.
N_ADDR_W, $clog2(`BP_ADDR_DEPTH), BPU entry index width.
N_FIFO_DEPTH, 4, update queue depth; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s0_valid  in  1  lane0 update valid
s0_ready  out  1  lane0 accepted
s0_upd  in  UPD_W  lane0 packed update record (see Decomposition)
s1_valid  in  1  lane1 update valid
s1_ready  out  1  lane1 accepted
s1_upd  in  UPD_W  lane1 packed record
kill  in  1  drop all queued, not-yet-issued updates
hold  in  1  stall issue to the BPU; enqueue still allowed
busy  out  1  FIFO non-empty or output register valid
flush_valid  out  1  to BPU
flush_new_pc  out  1  to BPU
flush_type  out  N_FLUSH_BYTE_BITS  to BPU
flush_addr  out  N_ADDR_W  to BPU
flush_bp_pc  out  N_ADDR_BITS  to BPU
flush_pc  out  N_DATA_BITS  to BPU
flush_ras_valid  out  1  to BPU
flush_ras_type  out  2  to BPU
flush_ras_pc  out  N_DATA_BITS  to BPU

Behaviour:
- Reset: all flush_* outputs are 0; FIFO is empty; wr/rd pointers are 0; rr pointer is 0 (lane0 preferred); busy is 0.
- Clock and reset: single clock clk; reset rstn is asynchronous and active-low.
- Handshake: a transfer occurs when sX_valid && sX_ready. The record is sampled at that edge.
- The free count is computed from the start-of-cycle count; a same-cycle pop does not add space.
- free >= 2: both ready=1. Same-cycle double push writes lane0 at wr_ptr and lane1 at wr_ptr+1.
- free == 1:
  - Only one valid: that lane gets ready.
  - Both valid: the rr lane gets ready, and rr flips to the other lane.
  - rr also flips whenever only the non-preferred lane is granted.
- free == 0 or kill=1: both ready=0.
- Issue: when !hold && !empty, pop the head into the registered flush_* outputs with flush_valid=1 for exactly one cycle. Otherwise flush_valid=0 next cycle and the other flush_* outputs hold their values.
- Latency: an entry pushed in cycle N reaches flush_valid in cycle N+1 at the earliest. Throughput is 1 update per cycle.
- Order: entries issue in FIFO order. A lane0 push precedes a lane1 push in the same cycle.
- kill:
  - Pointers and count are cleared at the next edge.
  - No pop occurs in the kill cycle, and the output register's flush_valid is forced to 0 next cycle.
  - An update already showing flush_valid=1 during the kill cycle has been consumed by the BPU and is not retracted.
- hold: blocks the pop only. Push continues until the FIFO is full. Releasing hold resumes issue on the next cycle.
- Simultaneous push and pop at full: not allowed (ready=0). At empty, a push and a pop in the same cycle cannot occur; the pop needs entries present at the start of the cycle.
- Pointers are N_FIFO_DEPTH-wide modulo with wrap-around. The count is $clog2(N_FIFO_DEPTH)+1 bits.
- A record with new_pc=0 and type=0 is passed through untouched; the BPU treats it as not-taken training.
- busy = !empty | flush_valid.

Optional Feature:
- Macro: BPU_UPD_STAT_EN.
- When defined, add outputs stat_issued[31:0], stat_killed[31:0] and stat_stall[31:0], all reset to 0 and saturating:
  - stat_issued increments per flush_valid cycle.
  - stat_killed increments by the entry count discarded on kill.
  - stat_stall increments per cycle in which any sX_valid && !sX_ready.
- When not defined, these ports and counters do not exist, and the block's behaviour is otherwise identical.

Decomposition:
- Shared package/header bpu_pkg holds:
  - The update record typedef, with fields in MSB-to-LSB order: new_pc, type[3:0], addr, bp_pc, pc, ras_valid, ras_type[1:0], ras_pc.
  - UPD_W.
  - Type bit positions CALL=3, RET=2, JAL_JALR=1, BRANCH=0.
  - RAS types NONE=00, PUSH=01, POP=10, POPPUSH=11.
- One sub-module: bpu_upd_fifo, a 2-write/1-read synchronous FIFO with clear. Arbitration and output registers stay in the top level.

Test Plan:
1. Reset, then s0 push {new_pc=1, type=0001, bp_pc=0x40, pc=0x80} at cycle 1 -> flush_valid=1 at cycle 2 only with matching fields; busy drops at cycle 3.
2. Both lanes valid every cycle, hold=1 -> exactly 4 entries accepted (2+2). Then both valid at free=0 -> ready=0. Release hold -> issue order s0,s1,s0,s1; after one pop with both still valid, grant alternates by rr.
3. Fill 3 entries, hold=0, assert kill in the cycle that shows flush_valid for entry 0 -> entry 0 is seen once, entries 1-2 never issue, FIFO is empty next cycle, and s0_ready=0 during kill.
4. Pointer wrap: 10 single pushes with one pop per cycle -> 10 in-order issues with no loss or duplication.
5. Assert rstn low while 2 entries are queued and flush_valid=1 -> all outputs are 0 immediately (asynchronously); after release, nothing issues.
6. With BPU_UPD_STAT_EN: scenario 2 then 3 -> stat_issued, stat_killed and stat_stall match the scoreboard counts exactly.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types for the BPU update path: update record, branch-type bit positions, RAS op codes.
// BP_ADDR_BITS / BP_ADDR_DEPTH fall back to local defaults when the core config does not supply them.
`ifndef BP_ADDR_BITS
`define BP_ADDR_BITS 12
`endif
`ifndef BP_ADDR_DEPTH
`define BP_ADDR_DEPTH 64
`endif

package bpu_pkg;
    localparam int N_ADDR_BITS       = `BP_ADDR_BITS;
    localparam int N_DATA_BITS       = 32;
    localparam int N_FLUSH_BYTE_BITS = 4;
    localparam int N_ADDR_W          = $clog2(`BP_ADDR_DEPTH);

    localparam int BT_CALL     = 3;
    localparam int BT_RET      = 2;
    localparam int BT_JAL_JALR = 1;
    localparam int BT_BRANCH   = 0;

    typedef enum logic [1:0] {
        RAS_NONE    = 2'b00,
        RAS_PUSH    = 2'b01,
        RAS_POP     = 2'b10,
        RAS_POPPUSH = 2'b11
    } ras_type_e;

    typedef struct packed {
        logic                         new_pc;
        logic [N_FLUSH_BYTE_BITS-1:0] br_type;
        logic [N_ADDR_W-1:0]          addr;
        logic [N_ADDR_BITS-1:0]       bp_pc;
        logic [N_DATA_BITS-1:0]       pc;
        logic                         ras_valid;
        ras_type_e                    ras_type;
        logic [N_DATA_BITS-1:0]       ras_pc;
    } upd_t;

    localparam int UPD_W = $bits(upd_t);

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction
endpackage

// File: rtl/bpu_upd_sched_if.sv
// Execute-lane update handshakes plus the BPU flush/update port.
interface bpu_upd_sched_if;
    import bpu_pkg::*;

    logic                         s0_valid;
    logic                         s0_ready;
    upd_t                         s0_upd;
    logic                         s1_valid;
    logic                         s1_ready;
    upd_t                         s1_upd;

    logic                         flush_valid;
    logic                         flush_new_pc;
    logic [N_FLUSH_BYTE_BITS-1:0] flush_type;
    logic [N_ADDR_W-1:0]          flush_addr;
    logic [N_ADDR_BITS-1:0]       flush_bp_pc;
    logic [N_DATA_BITS-1:0]       flush_pc;
    logic                         flush_ras_valid;
    logic [1:0]                   flush_ras_type;
    logic [N_DATA_BITS-1:0]       flush_ras_pc;

    modport master (
        output s0_valid, s0_upd, s1_valid, s1_upd,
        input  s0_ready, s1_ready,
        input  flush_valid, flush_new_pc, flush_type, flush_addr, flush_bp_pc,
               flush_pc, flush_ras_valid, flush_ras_type, flush_ras_pc
    );

    modport slave (
        input  s0_valid, s0_upd, s1_valid, s1_upd,
        output s0_ready, s1_ready,
        output flush_valid, flush_new_pc, flush_type, flush_addr, flush_bp_pc,
               flush_pc, flush_ras_valid, flush_ras_type, flush_ras_pc
    );
endinterface

// File: rtl/bpu_upd_fifo.sv
// 2-write/1-read update queue with synchronous clear; wr0 lands before wr1 when both fire.
// Latency: written entries are visible at rd_dat the next cycle.
// Backpressure: none internally; the caller gates writes/reads with cnt.
module bpu_upd_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          wr0_en,
    input  upd_t          wr0_dat,
    input  logic          wr1_en,
    input  upd_t          wr1_dat,
    input  logic          rd_en,
    output upd_t          rd_dat,
    output logic [CW-1:0] cnt
);
    upd_t          mem_q [DEPTH];
    upd_t          mem_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, wp_nxt;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d  = mem_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        wp_nxt = wp_q + PW'(1);
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (wr0_en) mem_d[wp_q] = wr0_dat;
            // lane1 takes the slot after lane0 only when both push together
            if (wr1_en) mem_d[wr0_en ? wp_nxt : wp_q] = wr1_dat;
            wp_d  = wp_q + PW'(wr0_en) + PW'(wr1_en);
            rp_d  = rp_q + PW'(rd_en);
            cnt_d = cnt_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign rd_dat = mem_q[rp_q];
    assign cnt    = cnt_q;
endmodule

// File: rtl/bpu_upd_sched.sv
// Two-lane BPU training-update scheduler; BPU_UPD_STAT_EN adds saturating issue/kill/stall counters.
// Latency: a push in cycle N can show flush_valid in cycle N+1; one issue per cycle.
// Backpressure: lane ready drops on a full queue or kill; at one free slot a round-robin pointer picks.
module bpu_upd_sched
    import bpu_pkg::*;
#(
    parameter int N_FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    bpu_upd_sched_if.slave   io,
    input  logic             kill,
    input  logic             hold,
    output logic             busy
`ifdef BPU_UPD_STAT_EN
   ,output logic [31:0]      stat_issued,
    output logic [31:0]      stat_killed,
    output logic [31:0]      stat_stall
`endif
);
    localparam int            CW      = $clog2(N_FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(N_FIFO_DEPTH);

    logic [CW-1:0] cnt, free;
    logic          empty, pop, push0, push1;
    logic          s0_rdy, s1_rdy;
    logic          rr_q, rr_d;
    logic          flush_vld_q, flush_vld_d;
    upd_t          flush_q, flush_d, head;

    bpu_upd_fifo #(.DEPTH(N_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (kill),
        .wr0_en  (push0),
        .wr0_dat (io.s0_upd),
        .wr1_en  (push1),
        .wr1_dat (io.s1_upd),
        .rd_en   (pop),
        .rd_dat  (head),
        .cnt     (cnt)
    );

    // Space is judged from the start-of-cycle count; a same-cycle pop frees nothing.
    assign free  = DEPTH_C - cnt;
    assign empty = (cnt == '0);
    assign pop   = !hold && !empty && !kill;
    assign push0 = io.s0_valid && s0_rdy;
    assign push1 = io.s1_valid && s1_rdy;

    always_comb begin
        s0_rdy = 1'b0;
        s1_rdy = 1'b0;
        rr_d   = rr_q;
        if (!kill) begin
            if (free >= CW'(2)) begin
                s0_rdy = 1'b1;
                s1_rdy = 1'b1;
            end else if (free == CW'(1)) begin
                if (io.s0_valid && io.s1_valid) begin
                    s0_rdy = !rr_q;
                    s1_rdy = rr_q;
                    rr_d   = !rr_q;
                end else if (io.s0_valid) begin
                    s0_rdy = 1'b1;
                    rr_d   = 1'b0;
                end else if (io.s1_valid) begin
                    s1_rdy = 1'b1;
                    rr_d   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        flush_vld_d = pop;
        flush_d     = pop ? head : flush_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q        <= 1'b0;
            flush_vld_q <= 1'b0;
            flush_q     <= '0;
        end else begin
            rr_q        <= rr_d;
            flush_vld_q <= flush_vld_d;
            flush_q     <= flush_d;
        end
    end

    assign io.s0_ready        = s0_rdy;
    assign io.s1_ready        = s1_rdy;
    assign io.flush_valid     = flush_vld_q;
    assign io.flush_new_pc    = flush_q.new_pc;
    assign io.flush_type      = flush_q.br_type;
    assign io.flush_addr      = flush_q.addr;
    assign io.flush_bp_pc     = flush_q.bp_pc;
    assign io.flush_pc        = flush_q.pc;
    assign io.flush_ras_valid = flush_q.ras_valid;
    assign io.flush_ras_type  = flush_q.ras_type;
    assign io.flush_ras_pc    = flush_q.ras_pc;
    assign busy               = !empty || flush_vld_q;

`ifdef BPU_UPD_STAT_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_killed_q, stat_killed_d;
    logic [31:0] stat_stall_q,  stat_stall_d;

    always_comb begin
        stat_issued_d = sat_add(stat_issued_q, {31'd0, flush_vld_q});
        stat_killed_d = sat_add(stat_killed_q, kill ? 32'(cnt) : 32'd0);
        stat_stall_d  = sat_add(stat_stall_q,
                                {31'd0, (io.s0_valid && !s0_rdy) || (io.s1_valid && !s1_rdy)});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_issued_q <= '0;
            stat_killed_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_killed_q <= stat_killed_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_killed = stat_killed_q;
    assign stat_stall  = stat_stall_q;
`endif
endmodule

// File: tb/tb_bpu_upd_sched.sv
// Directed + random stimulus against a queue-based model of the update scheduler.
module tb_bpu_upd_sched;
    import bpu_pkg::*;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rstn;
    logic kill, hold, busy;
`ifdef BPU_UPD_STAT_EN
    logic [31:0] stat_issued, stat_killed, stat_stall;
`endif

    bpu_upd_sched_if io();

    bpu_upd_sched #(.N_FIFO_DEPTH(D)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (io),
        .kill (kill),
        .hold (hold),
        .busy (busy)
`ifdef BPU_UPD_STAT_EN
       ,.stat_issued (stat_issued),
        .stat_killed (stat_killed),
        .stat_stall  (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model state
    upd_t        mq[$];
    bit          pref;
    bit          m_vld;
    upd_t        m_out;
    int unsigned m_issued, m_killed, m_stall;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pref     = 1'b0;
        m_vld    = 1'b0;
        m_out    = '0;
        m_issued = 0;
        m_killed = 0;
        m_stall  = 0;
    endtask

    function automatic upd_t rnd_upd();
        upd_t u;
        u.new_pc    = 1'($urandom);
        u.br_type   = 4'($urandom);
        u.addr      = N_ADDR_W'($urandom);
        u.bp_pc     = N_ADDR_BITS'($urandom);
        u.pc        = $urandom;
        u.ras_valid = 1'($urandom);
        u.ras_type  = ras_type_e'($urandom_range(0, 3));
        u.ras_pc    = $urandom;
        return u;
    endfunction

    task automatic check_outputs();
        upd_t obs;
        obs.new_pc    = io.flush_new_pc;
        obs.br_type   = io.flush_type;
        obs.addr      = io.flush_addr;
        obs.bp_pc     = io.flush_bp_pc;
        obs.pc        = io.flush_pc;
        obs.ras_valid = io.flush_ras_valid;
        obs.ras_type  = ras_type_e'(io.flush_ras_type);
        obs.ras_pc    = io.flush_ras_pc;
        chk("flush_valid", io.flush_valid, m_vld);
        chk("flush_rec", obs, m_out);
        chk("busy", busy, (mq.size() != 0) || m_vld);
`ifdef BPU_UPD_STAT_EN
        chk("stat_issued", stat_issued, m_issued);
        chk("stat_killed", stat_killed, m_killed);
        chk("stat_stall", stat_stall, m_stall);
`endif
    endtask

    // Called just after a negedge: drive inputs, check readies, advance the model one edge.
    task automatic cycle(input bit v0, input bit v1, input upd_t u0, input upd_t u1,
                         input bit kl, input bit hd);
        int free;
        bit r0, r1;
        io.s0_valid = v0; io.s0_upd = u0;
        io.s1_valid = v1; io.s1_upd = u1;
        kill = kl; hold = hd;
        #1;
        free = D - mq.size();
        r0 = 1'b0; r1 = 1'b0;
        if (!kl && free >= 2) begin
            r0 = 1'b1; r1 = 1'b1;
        end else if (!kl && free == 1) begin
            if (v0 && v1) begin
                r0 = (pref == 1'b0); r1 = (pref == 1'b1); pref = !pref;
            end else if (v0) begin
                r0 = 1'b1; pref = 1'b0;
            end else if (v1) begin
                r1 = 1'b1; pref = 1'b1;
            end
        end
        if (!(free == 1 && !kl && !v0)) chk("s0_ready", io.s0_ready, r0);
        if (!(free == 1 && !kl && !v1)) chk("s1_ready", io.s1_ready, r1);

        if (m_vld) m_issued++;
        if ((v0 && !r0) || (v1 && !r1)) m_stall++;
        if (kl) begin
            m_killed += mq.size();
            mq.delete();
            m_vld = 1'b0;
        end else if (!hd && mq.size() != 0) begin
            m_out = mq.pop_front();
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        if (v0 && r0) mq.push_back(u0);
        if (v1 && r1) mq.push_back(u1);

        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        upd_t t1;
        rstn = 1'b0;
        kill = 1'b0; hold = 1'b0;
        io.s0_valid = 1'b0; io.s0_upd = '0;
        io.s1_valid = 1'b0; io.s1_upd = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rstn = 1'b1;

        // single push, one-cycle issue, busy falls afterwards
        t1 = '0;
        t1.new_pc = 1'b1; t1.br_type = 4'b0001; t1.bp_pc = 'h40; t1.pc = 32'h80;
        cycle(1'b1, 1'b0, t1, '0, 1'b0, 1'b0);
        idle(3);

        // fill under hold with both lanes, then release with both still valid
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, rnd_upd(), rnd_upd(), 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, rnd_upd(), rnd_upd(), 1'b0, 1'b0);
        idle(6);

        // kill while entry 0 shows flush_valid
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, rnd_upd(), '0, 1'b0, 1'b1);
        idle(1);
        cycle(1'b1, 1'b0, rnd_upd(), '0, 1'b1, 1'b0);
        idle(3);

        // pointer wrap: continuous single pushes with concurrent pops
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, rnd_upd(), '0, 1'b0, 1'b0);
        idle(3);

        // random traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, rnd_upd(), rnd_upd(),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
        idle(6);

        // asynchronous reset while entries are queued and one is issuing
        cycle(1'b1, 1'b1, rnd_upd(), rnd_upd(), 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("pre_reset_valid", io.flush_valid, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rstn = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
